mux2_pkt_sched: RTL and testbench
=================================

Name: mux2_pkt_sched

Overview:
- Packet-level round-robin scheduler that shares one 2:1 data mux between two valid/ready requester streams (in0, in1) and one output stream.
- It arbitrates at packet boundaries and drives the mux select.
- Each packet is held until its last beat is accepted, so packets from the two requesters never interleave.
- A single output register stage sits behind the mux; the block feeds one downstream consumer.

Parameters:
- WIDTH, 8, data bits per beat.
- CNT_W, 8, width of per-input completed-packet counters (wrap-around).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
- in0_valid  input  1  requester 0 beat valid
- in0_data  input  WIDTH  requester 0 beat data
- in0_last  input  1  requester 0 final beat of packet
- in0_ready  output  1  requester 0 beat accepted when in0_valid & in0_ready
- in1_valid  input  1  requester 1 beat valid
- in1_data  input  WIDTH  requester 1 beat data
- in1_last  input  1  requester 1 final beat of packet
- in1_ready  output  1  requester 1 beat accepted when in1_valid & in1_ready
- out_valid  output  1  registered output beat valid
- out_data  output  WIDTH  registered output data
- out_last  output  1  registered output last flag
- out_ready  input  1  downstream accepts when out_valid & out_ready
- select  output  1  current mux select (0 = in0, 1 = in1); meaningful only while busy
- busy  output  1  a packet grant is active
- pkt_cnt0  output  CNT_W  packets completed from in0
- pkt_cnt1  output  CNT_W  packets completed from in1

Behaviour:
- Reset (rst_n == 0 at a clk edge) forces the following on the next edge, regardless of any in-flight packet:
  - state IDLE;
  - priority pointer ptr = 0 (in0 preferred);
  - select, busy, out_valid, out_data, out_last = 0;
  - pkt_cnt0, pkt_cnt1 = 0.
- A packet in flight at reset is discarded. Ready outputs are 0 throughout reset.
- States: IDLE, BUSY0, BUSY1. select = 1 only in BUSY1; busy = 1 in BUSY0/BUSY1.
- IDLE transitions:
  - neither valid -> stay IDLE;
  - exactly one valid -> BUSYx for that input;
  - both valid -> BUSY[ptr].
  - No beat is accepted in IDLE: in0_ready = in1_ready = 0, giving a one-cycle arbitration bubble.
- BUSYx:
  - inx_ready = (!out_valid | out_ready); the other input's ready = 0.
  - An accepted beat loads out_data/out_last and sets out_valid on the next edge.
  - Beat latency is 1 cycle, and full throughput is 1 beat/cycle while out_ready stays high.
- Output register:
  - If an accept occurs, load the new beat.
  - Else if out_ready, clear out_valid.
  - Else hold out_valid, out_data and out_last stable.
- Last beat: on acceptance of a beat with inx_last = 1, the next state is IDLE, ptr = ~x, and pkt_cntx increments, wrapping from 2^CNT_W-1 to 0.
- Single-beat packet (valid & last on the first accepted beat) completes in one BUSY cycle.
- A requester deasserting valid mid-packet keeps the grant (BUSY is held indefinitely); no timeout.
- The other requester's valid is ignored while busy, regardless of how long it waits.
- Packet-to-packet spacing from the same or the other requester is at least one IDLE cycle.
- in*_data and in*_last are don't-care when the corresponding valid = 0.

Decomposition:
- Shared package mux2_sched_pkg:
  - state encoding typedef/localparams (IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2);
  - default WIDTH and CNT_W constants.
- One natural sub-module: mux2_out_reg. It holds the registered valid/data/last output stage and produces the "can accept" term (!out_valid | out_ready). It is reused by any future N:1 scheduler.

Test Plan:
- Reset mid-packet:
  - Stimulus: in0 sends beats 0x11, 0x22 without last, then rst_n = 0 for 1 cycle.
  - Response: out_valid = 0, busy = 0, pkt_cnt0 = 0 after that edge.
  - A new in1 packet afterwards is granted (ptr = 0 but in0 idle).
- Contention round-robin:
  - Stimulus: both hold valid with 2-beat packets (in0: 0xA0, 0xA1 last; in1: 0xB0, 0xB1 last), out_ready = 1.
  - Response: output order is A0, A1, B0, B1, A0…, with one bubble between packets and select toggling 0->1->0.
- Backpressure:
  - Stimulus: in1 3-beat packet 0x01, 0x02, 0x03; out_ready low for 3 cycles after the first beat.
  - Response: out_data holds 0x01 and in1_ready = 0 while stalled.
  - All beats are delivered once, in order; out_last is set only with 0x03.
- Single-beat packets:
  - Stimulus: in0 sends 4 single-beat packets back-to-back, in1 idle.
  - Response: each is granted after one IDLE cycle; pkt_cnt0 = 4, pkt_cnt1 = 0.
- Counter wrap:
  - Stimulus: 256 single-beat packets on in1 with CNT_W = 8.
  - Response: pkt_cnt1 reads 255 then 0.
- Grant hold:
  - Stimulus: in0 deasserts valid for 5 cycles mid-packet while in1_valid = 1.
  - Response: state stays BUSY0, in1_ready = 0, no in1 beat appears until in0's last beat is accepted.

Source files
------------

// File: rtl/mux2_sched_pkg.sv
// Shared types and defaults for the two-input packet scheduler and its output stage.
package mux2_sched_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_e;

  // in1 wins when it alone is valid, or on a tie when the pointer favours it
  function automatic logic grant_in1(input logic v0, input logic v1, input logic ptr);
    return v1 & (~v0 | ptr);
  endfunction

endpackage

// File: rtl/mux2_out_reg.sv
// Single registered valid/data/last stage behind the scheduler mux.
// Exposes can_accept_o so the arbiter can pace beat acceptance.
module mux2_out_reg
  import mux2_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             can_accept_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign can_accept_o = ~valid_q | out_ready_i;
  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign out_last_o   = last_q;

endmodule

// File: rtl/mux2_pkt_sched.sv
// Packet-level round-robin scheduler sharing one 2:1 mux between two requesters.
//   state    | meaning
//   ST_IDLE  | no grant; arbitrate, accept nothing (one-cycle bubble)
//   ST_BUSY0 | in0 owns the mux until its last beat is accepted
//   ST_BUSY1 | in1 owns the mux until its last beat is accepted
module mux2_pkt_sched
  import mux2_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             select,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             can_accept;
  logic             acc0, acc1;
  logic [WIDTH-1:0] load_data;
  logic             load_last;

  assign acc0 = in0_valid & in0_ready;
  assign acc1 = in1_valid & in1_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (in0_valid | in1_valid)
          state_d = grant_in1(in0_valid, in1_valid, ptr_q) ? ST_BUSY1 : ST_BUSY0;
      end
      ST_BUSY0: begin
        if (acc0 && in0_last) begin
          state_d = ST_IDLE;
          ptr_d   = 1'b1;
          cnt0_d  = cnt0_q + CNT_W'(1);
        end
      end
      ST_BUSY1: begin
        if (acc1 && in1_last) begin
          state_d = ST_IDLE;
          ptr_d   = 1'b0;
          cnt1_d  = cnt1_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Readies are gated by rst_n so nothing is accepted during the reset cycle.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    select    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_BUSY0: begin
        busy      = 1'b1;
        in0_ready = rst_n & can_accept;
      end
      ST_BUSY1: begin
        busy      = 1'b1;
        select    = 1'b1;
        in1_ready = rst_n & can_accept;
      end
      default: ;
    endcase
    load_data = select ? in1_data : in0_data;
    load_last = select ? in1_last : in0_last;
  end

  mux2_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (acc0 | acc1),
    .data_i       (load_data),
    .last_i       (load_last),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .can_accept_o (can_accept)
  );

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mux2_pkt_sched.sv
// Directed bench for mux2_pkt_sched: reset, contention, backpressure, single beats, wrap, grant hold.
module tb_mux2_pkt_sched;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in0_last, in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in1_valid, in1_last, in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             out_valid, out_last, out_ready;
  logic [WIDTH-1:0] out_data;
  logic             select, busy;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  mux2_pkt_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .select    (select),
    .busy      (busy),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];
  bit         idle_en = 1'b0;
  int         idle_cnt = 0;
  bit         sel_en = 1'b0;
  int         sel_n = 0;
  logic [7:0] sel_trace = '0;
  logic       sel_last = 1'b0;
  int         c0;
  int         k;

  always @(posedge clk) cyc <= cyc + 1;

  // Output beats are logged where they will be consumed at the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) log_q.push_back({out_last, out_data});
    if (idle_en && !busy) idle_cnt++;
    if (sel_en && busy && (sel_n == 0 || select != sel_last)) begin
      sel_trace = {sel_trace[6:0], select};
      sel_last  = select;
      sel_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int port, input logic v, input logic [7:0] d, input logic l);
    if (port == 0) begin
      in0_valid = v; in0_data = d; in0_last = l;
    end else begin
      in1_valid = v; in1_data = d; in1_last = l;
    end
  endtask

  // Presents n beats (low byte first), holding each until accepted.
  task automatic send(input int port, input int n, input logic [31:0] beats, input bit with_last);
    bit acc;
    int wait_k;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      wait_k = 0;
      set_in(port, 1'b1, beats[8*i +: 8], with_last && (i == n - 1));
      while (!acc && wait_k < 200) begin
        @(negedge clk);
        acc = (port == 0) ? (in0_valid & in0_ready) : (in1_valid & in1_ready);
        @(posedge clk);
        #1;
        wait_k++;
      end
      if (!acc) chk($sformatf("accept_timeout_p%0d_b%0d", port, i), 32'd0, 32'd1);
    end
    set_in(port, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_log();
    chk("log_len", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) chk($sformatf("beat%0d", i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic drain();
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    set_in(0, 1'b1, 8'h77, 1'b1);
    set_in(1, 1'b1, 8'h88, 1'b1);
    #1;
    chk("rst_in0_ready", 32'(in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(in1_ready), 32'd0);
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
    chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);

    // Reset in the middle of an in0 packet
    do_reset();
    send(0, 2, 32'h0000_2211, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in0_ready", 32'(in0_ready), 32'd0);
    step();
    rst_n = 1'b1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cnt0", 32'(pkt_cnt0), 32'd0);
    log_q.delete();
    send(1, 1, 32'h0000_005A, 1'b1);
    drain();
    exp_q = {9'h15A};
    check_log();
    chk("mid_cnt1", 32'(pkt_cnt1), 32'd1);

    // Contention: both requesters stream 2-beat packets
    do_reset();
    idle_cnt = 0; idle_en = 1'b1;
    sel_n = 0; sel_trace = '0; sel_en = 1'b1;
    fork
      begin
        send(0, 2, 32'h0000_A1A0, 1'b1);
        send(0, 2, 32'h0000_A1A0, 1'b1);
      end
      begin
        send(1, 2, 32'h0000_B1B0, 1'b1);
        send(1, 2, 32'h0000_B1B0, 1'b1);
      end
    join
    idle_en = 1'b0;
    sel_en = 1'b0;
    drain();
    chk("rr_idle_cycles", 32'(idle_cnt), 32'd4);
    chk("rr_sel_changes", 32'(sel_n), 32'd4);
    chk("rr_sel_trace", 32'(sel_trace), 32'h05);
    exp_q = {9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
    check_log();
    chk("rr_cnt0", 32'(pkt_cnt0), 32'd2);
    chk("rr_cnt1", 32'(pkt_cnt1), 32'd2);

    // Backpressure on a 3-beat in1 packet
    do_reset();
    fork
      send(1, 3, 32'h0003_0201, 1'b1);
      begin
        k = 0;
        while (!out_valid && k < 20) begin
          step();
          k++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_data", 32'(out_data), 32'h01);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_in1_ready", 32'(in1_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    exp_q = {9'h001, 9'h002, 9'h103};
    check_log();

    // Back-to-back single-beat packets on in0
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(0, 1, 32'(8'h40 + i), 1'b1);
    chk("sb_cycles", 32'(cyc - c0), 32'd8);
    drain();
    exp_q = {9'h140, 9'h141, 9'h142, 9'h143};
    check_log();
    chk("sb_cnt0", 32'(pkt_cnt0), 32'd4);
    chk("sb_cnt1", 32'(pkt_cnt1), 32'd0);

    // Counter wrap on in1
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(1, 1, 32'(i & 8'hFF), 1'b1);
      if (i == 254) chk("wrap_cnt1_255", 32'(pkt_cnt1), 32'd255);
      if (i == 255) chk("wrap_cnt1_0", 32'(pkt_cnt1), 32'd0);
    end
    drain();
    chk("wrap_cnt0", 32'(pkt_cnt0), 32'd0);

    // Grant hold while in0 pauses mid-packet and in1 waits
    do_reset();
    fork
      begin
        send(0, 1, 32'h0000_00C0, 1'b0);
        repeat (5) begin
          @(negedge clk);
          chk("hold_busy", 32'(busy), 32'd1);
          chk("hold_select", 32'(select), 32'd0);
          chk("hold_in1_ready", 32'(in1_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        send(0, 1, 32'h0000_00C1, 1'b1);
      end
      send(1, 1, 32'h0000_00D0, 1'b1);
    join
    drain();
    exp_q = {9'h0C0, 9'h1C1, 9'h1D0};
    check_log();
    chk("hold_cnt0", 32'(pkt_cnt0), 32'd1);
    chk("hold_cnt1", 32'(pkt_cnt1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
